// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// mem_access_stage: memory stage of the pipelined LEGv8 datapath.
// Holds the EX/MEM pipeline register, resolves branches, drives a req/ack
// data-memory port with variable latency and produces the MEM/WB register.
// An access that waits more than ACK_TIMEOUT cycles for dm_ack parks the
// stage in a sticky error state that only reset clears.
// Optional build macro MISALIGN_TRAP_EN: memory operations whose address is
// not 8-byte aligned are trapped locally instead of reaching memory, and
// the extra output misalign_err flags them.
module mem_access_stage #(
   parameter int N           = 64,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic         Branch_E,
   input  logic         memRead_E,
   input  logic         memWrite_E,
   input  logic         regWrite_E,
   input  logic         memtoReg_E,
   input  logic [4:0]   rd_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic         zero_E,
   input  logic [N-1:0] PCBranch_E,
   output logic         stall_M,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_M,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic         dm_ack,
   input  logic [N-1:0] dm_rdata,
   output logic         valid_W,
   output logic         regWrite_W,
   output logic         memtoReg_W,
   output logic [4:0]   rd_W,
   output logic [N-1:0] aluResult_W,
   output logic [N-1:0] readData_W,
`ifdef MISALIGN_TRAP_EN
   output logic         misalign_err,
`endif
   output logic         bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

   state_t       state;
   logic [7:0]   wait_cnt;

   logic         valid_M;
   logic         Branch_M;
   logic         memRead_M;
   logic         memWrite_M;
   logic         regWrite_M;
   logic         memtoReg_M;
   logic [4:0]   rd_M;
   logic [N-1:0] aluResult_M;
   logic [N-1:0] writeData_M;
   logic         zero_M;

   logic         memop_M;
   logic         misalign_M;
   logic         mem_access;
   logic         in_err;

   assign memop_M = valid_M & (memRead_M | memWrite_M);

`ifdef MISALIGN_TRAP_EN
   assign misalign_M   = memop_M & (aluResult_M[2:0] != 3'b000);
   assign misalign_err = misalign_M;
`else
   assign misalign_M   = 1'b0;
`endif

   // A trapped access never reaches memory; everything else that is a real
   // load or store goes out on the port unless the stage is parked in error.
   assign mem_access = memop_M & ~misalign_M;
   assign in_err     = (state == ST_ERR);

   assign dm_req   = mem_access & ~in_err;
   assign dm_we    = memWrite_M;
   assign dm_addr  = aluResult_M;
   assign dm_wdata = writeData_M;

   // Upstream is held while an access waits for its ack, and forever once
   // the error state is reached. An ack in the issue cycle means no stall.
   assign stall_M = in_err | (mem_access & ~dm_ack);

   assign PCSrc_M = valid_M & Branch_M & zero_M;

   // EX/MEM pipeline register: capture execute results unless stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_M     <= 1'b0;
         Branch_M    <= 1'b0;
         memRead_M   <= 1'b0;
         memWrite_M  <= 1'b0;
         regWrite_M  <= 1'b0;
         memtoReg_M  <= 1'b0;
         rd_M        <= '0;
         aluResult_M <= '0;
         writeData_M <= '0;
         zero_M      <= 1'b0;
         PCBranch_M  <= '0;
      end else if (!stall_M) begin
         valid_M     <= valid_E;
         Branch_M    <= Branch_E;
         memRead_M   <= memRead_E;
         memWrite_M  <= memWrite_E;
         regWrite_M  <= regWrite_E;
         memtoReg_M  <= memtoReg_E;
         rd_M        <= rd_E;
         aluResult_M <= aluResult_E;
         writeData_M <= writeData_E;
         zero_M      <= zero_E;
         PCBranch_M  <= PCBranch_E;
      end
   end

   // Access tracker: counts cycles spent waiting for dm_ack and latches the
   // sticky bus error when the wait exceeds the timeout; an ack on the
   // timeout cycle itself still completes the access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (dm_req && !dm_ack) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            ST_WAIT: begin
               if (dm_ack) begin
                  state    <= ST_IDLE;
                  wait_cnt <= '0;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  state   <= ST_ERR;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_ERR: begin
               bus_err <= 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // MEM/WB pipeline register: retire the instruction in M, or insert a
   // bubble (controls cleared, data held) while the stage is stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_W     <= 1'b0;
         regWrite_W  <= 1'b0;
         memtoReg_W  <= 1'b0;
         rd_W        <= '0;
         aluResult_W <= '0;
         readData_W  <= '0;
      end else if (stall_M) begin
         valid_W    <= 1'b0;
         regWrite_W <= 1'b0;
         memtoReg_W <= 1'b0;
      end else begin
         valid_W     <= valid_M;
         regWrite_W  <= valid_M & regWrite_M & ~misalign_M;
         memtoReg_W  <= memtoReg_M;
         rd_W        <= rd_M;
         aluResult_W <= aluResult_M;
         readData_W  <= (memRead_M && dm_ack && !misalign_M) ? dm_rdata : '0;
      end
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the pipelined LEGv8 datapath; consumes the execute stage outputs (aluResult_E, writeData_E, zero_E, PCBranch_E) plus control bits.
- Holds the EX/MEM pipeline register and resolves branches (PCSrc).
- Drives a req/ack data-memory port with variable latency and stalls upstream while an access is outstanding.
- Produces the MEM/WB register contents for writeback.

Parameters:
- N, 64: datapath width (address, write data, read data).
- ACK_TIMEOUT, 15: max wait cycles for dm_ack before entering the error state; range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- valid_E  in  1  execute stage holds a real instruction.
- Branch_E, memRead_E, memWrite_E, regWrite_E, memtoReg_E  in  1 each  control bits from execute.
- rd_E  in  5  destination register.
- aluResult_E  in  N  address or ALU result.
- writeData_E  in  N  store data.
- zero_E  in  1  ALU zero flag.
- PCBranch_E  in  N  branch target.
- stall_M  out  1  hold execute/decode/fetch this cycle.
- PCSrc_M  out  1  take branch.
- PCBranch_M  out  N  registered branch target.
- dm_req  out  1  memory request.
- dm_we  out  1  write enable.
- dm_addr  out  N  address.
- dm_wdata  out  N  store data.
- dm_ack  in  1  memory completes the access this cycle.
- dm_rdata  in  N  load data, valid when dm_ack=1.
- valid_W, regWrite_W, memtoReg_W  out  1 each  writeback controls.
- rd_W  out  5  writeback destination.
- aluResult_W, readData_W  out  N  writeback data.
- bus_err  out  1  sticky access-timeout flag.

Behaviour:
- Reset: EX/MEM and MEM/WB registers cleared; every registered output 0; FSM in IDLE; wait counter 0.
- After reset, dm_req, PCSrc_M, stall_M and bus_err are 0 because they derive from cleared state.
- EX/MEM register:
  - If stall_M=0, captures all *_E inputs at the edge into *_M.
  - If stall_M=1, holds its contents.
- memop_M = valid_M & (memRead_M | memWrite_M).
- Memory port:
  - dm_req = memop_M & (state != ERR).
  - dm_we = memWrite_M; write has priority if both memRead_M and memWrite_M are set.
  - dm_addr = aluResult_M; dm_wdata = writeData_M.
  - Address, data and we stay stable while dm_req=1 and ack has not arrived.
- stall_M = memop_M & !(dm_ack & state != ERR). A zero-latency memory (ack in the same cycle) gives no stall.
- FSM:
  - IDLE: if dm_req & !dm_ack, go to WAIT and set counter to 1. Otherwise stay in IDLE.
  - WAIT: if dm_ack, go to IDLE. Otherwise, if counter == ACK_TIMEOUT, go to ERR. Otherwise increment the counter.
  - When ack and timeout occur in the same cycle, ack wins.
  - ERR: bus_err=1, dm_req=0, stall_M=1 permanently; exit only via reset.
- Branch:
  - PCSrc_M = valid_M & Branch_M & zero_M, combinational; PCBranch_M = registered PCBranch.
  - Branches are not memory ops and never stall.
- MEM/WB register:
  - If stall_M=0: valid_W <= valid_M; the remaining W controls, rd_W and aluResult_W copy from M; readData_W <= dm_rdata when memRead_M & dm_ack, else 0.
  - If stall_M=1: valid_W, regWrite_W and memtoReg_W are cleared (bubble); data fields hold.
- Invalid instruction (valid_M=0): no request, no PCSrc, propagates as valid_W=0 with regWrite_W=0.
- Reset mid-access: the synchronous reset clears valid_M, so dm_req is 0 in the cycle after the reset edge. The outstanding memory transaction is abandoned; the memory side must tolerate req drop.
- Back-to-back memory ops: the second enters EX/MEM on the same edge the first retires. The FSM returns to IDLE without a bubble cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - misalign_M = memop_M & (aluResult_M[2:0] != 0).
  - Such an access issues no dm_req and does not stall.
  - It retires with valid_W=1, regWrite_W=0, readData_W=0.
  - Extra output port misalign_err (1 bit) pulses for exactly that one cycle.
- Not defined: no misalign_err port; any address is passed to memory unchanged.

Test Plan:
- Load, addr 0x40, dm_ack same cycle, rdata 0xDEADBEEF → stall_M never 1; next edge readData_W=0xDEADBEEF, valid_W=1, memtoReg_W=1.
- Store 0x1234 to 0x80, ack after 3 cycles → dm_req=1, dm_we=1 for 3 cycles, addr/wdata stable, stall_M=1 for 2 cycles; valid_W bubbles, then the store retires.
- CBZ-style Branch_E=1, zero_E=1, PCBranch_E=0x100 → cycle after capture PCSrc_M=1, PCBranch_M=0x100. With zero_E=0 → PCSrc_M=0.
- Load with no ack, ACK_TIMEOUT=15 → ERR entered after 15 wait cycles, bus_err=1, dm_req=0, stall held. Assert reset → all outputs 0, state IDLE.
- Ack arriving on the exact timeout cycle → access completes, bus_err stays 0. Reset asserted during WAIT → dm_req=0 next cycle, valid_W=0.
- With MISALIGN_TRAP_EN: load at 0x44 → no dm_req, misalign_err=1 for one cycle, regWrite_W=0.
